layer1_mac_sequencer: RTL and testbench

Sequential replacement for the combinational layer1 dense stage of the generator (64 Q8.8 inputs -> 256 Q8.8 outputs).
- One shared multiply-accumulate unit is time-multiplexed over all 256 neurons.
- The block drives read addresses into the input buffer, weight ROM and bias ROM, accumulates 64 products per neuron, adds the bias, saturates, and writes each result to the output buffer.
- It sits between the latent-vector buffer and the layer-2 input buffer.

---
 rtl/layer1_mac_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_layer1_mac_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer1_mac_sequencer.sv
// -----------------------------------------------------------------------------
// layer1_mac_sequencer
//
// Sequential layer-1 dense stage of the generator: 64 Q8.8 inputs -> 256 Q8.8
// outputs. One shared multiply-accumulate unit is time-multiplexed over every
// neuron. For neuron j the block walks k = 0..N_IN-1, reads x[k], W[j][k] and
// b[j] from synchronous memories, accumulates the products on top of the
// bias, then writes the saturated result to the output buffer.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               begin one full layer pass (accepted only when idle)
//   abort               synchronous cancel; back to idle, no done pulse
//   busy                high while a pass is in progress
//   done                one-cycle pulse after the final output write
//   in_addr / in_data   input buffer read port (data valid 1 cycle later)
//   w_addr  / w_data    weight ROM read port, w_addr = j*N_IN + k
//   b_addr  / b_data    bias ROM read port, b_addr = j
//   out_we / out_addr / out_data   output buffer write port
// -----------------------------------------------------------------------------
module layer1_mac_sequencer #(
  parameter int N_IN   = 64,
  parameter int N_OUT  = 256,
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic                                     abort,
  output logic                                     busy,
  output logic                                     done,
  output logic [$clog2(N_IN)-1:0]                  in_addr,
  input  logic signed [DATA_W-1:0]                 in_data,
  output logic [$clog2(N_OUT)+$clog2(N_IN)-1:0]    w_addr,
  input  logic signed [DATA_W-1:0]                 w_data,
  output logic [$clog2(N_OUT)-1:0]                 b_addr,
  input  logic signed [DATA_W-1:0]                 b_data,
  output logic                                     out_we,
  output logic [$clog2(N_OUT)-1:0]                 out_addr,
  output logic [DATA_W-1:0]                        out_data
);

  localparam int K_W  = $clog2(N_IN);
  localparam int J_W  = $clog2(N_OUT);
  localparam int WA_W = J_W + K_W;
  localparam int P_W  = 2 * DATA_W;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    FLUSH = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                   state_reg, state_next;
  logic [J_W-1:0]           j_reg, j_next;
  logic [K_W-1:0]           k_reg, k_next;
  logic signed [ACC_W-1:0]  acc_reg, acc_next;
  // valid_reg: memory data on this cycle belongs to the address issued last
  // cycle in ACCUM. first_reg: that address was k=0, so the bias seeds acc.
  logic                     valid_reg, valid_next;
  logic                     first_reg, first_next;

  logic signed [P_W-1:0]    prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_scaled;
  logic signed [ACC_W-1:0]  acc_shift;
  logic [DATA_W-1:0]        sat_data;

  // Q8.8 * Q8.8 -> Q16.16; bias is lifted to the same Q.16 scale.
  assign prod        = in_data * w_data;
  assign prod_ext    = {{(ACC_W - P_W){prod[P_W-1]}}, prod};
  assign bias_scaled = {{(ACC_W - DATA_W){b_data[DATA_W-1]}}, b_data} <<< FRAC;

  // Back to Q8.8 by arithmetic shift (floor), then clamp to the word range.
  assign acc_shift = acc_reg >>> FRAC;

  always_comb begin
    sat_data = acc_shift[DATA_W-1:0];
    if (acc_shift > SAT_MAX) begin
      sat_data = SAT_MAX[DATA_W-1:0];
    end else if (acc_shift < SAT_MIN) begin
      sat_data = SAT_MIN[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      j_reg     <= '0;
      k_reg     <= '0;
      acc_reg   <= '0;
      valid_reg <= 1'b0;
      first_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      j_reg     <= j_next;
      k_reg     <= k_next;
      acc_reg   <= acc_next;
      valid_reg <= valid_next;
      first_reg <= first_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    j_next     = j_reg;
    k_next     = k_reg;
    acc_next   = acc_reg;
    valid_next = 1'b0;
    first_next = 1'b0;

    // Accumulate one cycle behind the address stream; this also covers the
    // FLUSH cycle, which consumes the product for k = N_IN-1.
    if (valid_reg) begin
      acc_next = first_reg ? (bias_scaled + prod_ext) : (acc_reg + prod_ext);
    end

    unique case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          state_next = ACCUM;
          j_next     = '0;
          k_next     = '0;
        end
      end
      ACCUM: begin
        valid_next = 1'b1;
        first_next = (k_reg == '0);
        // k stays at N_IN-1 on exit so the addresses hold through FLUSH/WRITE.
        if (k_reg == K_W'(N_IN - 1)) begin
          state_next = FLUSH;
        end else begin
          k_next = k_reg + K_W'(1);
        end
      end
      FLUSH: begin
        state_next = WRITE;
      end
      WRITE: begin
        if (j_reg == J_W'(N_OUT - 1)) begin
          state_next = DONE;
        end else begin
          state_next = ACCUM;
          j_next     = j_reg + J_W'(1);
          k_next     = '0;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (abort && (state_reg != IDLE)) begin
      state_next = IDLE;
      j_next     = '0;
      k_next     = '0;
      acc_next   = '0;
      valid_next = 1'b0;
      first_next = 1'b0;
    end
  end

  assign busy     = (state_reg == ACCUM) || (state_reg == FLUSH) || (state_reg == WRITE);
  assign done     = (state_reg == DONE);
  assign out_we   = (state_reg == WRITE);
  assign out_addr = j_reg;
  assign out_data = (state_reg == WRITE) ? sat_data : '0;
  assign in_addr  = k_reg;
  assign b_addr   = j_reg;
  assign w_addr   = WA_W'(j_reg) * WA_W'(N_IN) + WA_W'(k_reg);

endmodule

// File: tb/tb_layer1_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_layer1_mac_sequencer
//
// Directed bench for layer1_mac_sequencer. Synchronous memories are modelled
// here; expected writes are queued when each pass is launched and popped by a
// negedge monitor whenever the DUT strobes out_we.
// -----------------------------------------------------------------------------
module tb_layer1_mac_sequencer;

  localparam int N_IN  = 64;
  localparam int N_OUT = 256;
  localparam int PASS_CYCLES = N_OUT * (N_IN + 2) + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, out_we;
  logic [5:0]  in_addr;
  logic [13:0] w_addr;
  logic [7:0]  b_addr, out_addr;
  logic [15:0] in_data, w_data, b_data, out_data;

  layer1_mac_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .out_we   (out_we),
    .out_addr (out_addr),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  logic [15:0] in_mem [N_IN];
  logic [15:0] w_mem  [N_IN*N_OUT];
  logic [15:0] b_mem  [N_OUT];

  always @(posedge clk) begin
    in_data <= in_mem[in_addr];
    w_data  <= w_mem[w_addr];
    b_data  <= b_mem[b_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  int start_cyc = 0;
  int exp_done_cyc = 0;
  bit first_wr_pending = 1'b0;
  logic [23:0] exp_q [$];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor / scoreboard consumer
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_we) begin
        logic [23:0] e;
        wr_cnt++;
        $display("wr addr=%0d data=%h", out_addr, out_data);
        if (first_wr_pending) begin
          check("first_write_latency", cyc, start_cyc + 66);
          first_wr_pending = 1'b0;
        end
        if (exp_q.size() == 0) begin
          check("unexpected_write", out_we, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", out_addr, e[23:16]);
          check("wr_data", out_data, e[15:0]);
        end
      end
      if (done) begin
        done_cnt++;
        check("busy_in_done", busy, 1'b0);
        check("done_latency", cyc, exp_done_cyc);
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},     busy,     1'b0);
    check({tag, "_done"},     done,     1'b0);
    check({tag, "_out_we"},   out_we,   1'b0);
    check({tag, "_in_addr"},  in_addr,  6'd0);
    check({tag, "_w_addr"},   w_addr,   14'd0);
    check({tag, "_b_addr"},   b_addr,   8'd0);
    check({tag, "_out_addr"}, out_addr, 8'd0);
    check({tag, "_out_data"}, out_data, 16'd0);
  endtask

  // in = w = 1.0; bias 0 on even neurons, -1.0 on odd ones
  task automatic fill_unity();
    for (int k = 0; k < N_IN; k++) in_mem[k] = 16'h0100;
    for (int i = 0; i < N_IN*N_OUT; i++) w_mem[i] = 16'h0100;
    for (int j = 0; j < N_OUT; j++) b_mem[j] = j[0] ? 16'hFF00 : 16'h0000;
  endtask

  task automatic push_unity();
    for (int j = 0; j < N_OUT; j++) exp_q.push_back({8'(j), (j[0] ? 16'h3F00 : 16'h4000)});
  endtask

  // Neuron groups by j%8: 0 positive saturation, 1 negative saturation,
  // 2 tiny positive term truncates to 0, 3 tiny negative term floors to -1,
  // 4..7 all-zero weights so the bias passes straight through.
  task automatic fill_edge();
    for (int k = 0; k < N_IN; k++) in_mem[k] = (k < N_IN-1) ? 16'h7FFF : 16'h0001;
    for (int j = 0; j < N_OUT; j++) begin
      b_mem[j] = ((j % 8) >= 4) ? 16'(j*16) : 16'h0000;
      for (int k = 0; k < N_IN; k++) begin
        logic [15:0] w;
        case (j % 8)
          0: w = (k < N_IN-1) ? 16'h7FFF : 16'h0000;
          1: w = (k < N_IN-1) ? 16'h8000 : 16'h0000;
          2: w = (k == N_IN-1) ? 16'h0080 : 16'h0000;
          3: w = (k == N_IN-1) ? 16'hFF80 : 16'h0000;
          default: w = 16'h0000;
        endcase
        w_mem[j*N_IN + k] = w;
      end
    end
  endtask

  task automatic push_edge();
    for (int j = 0; j < N_OUT; j++) begin
      logic [15:0] v;
      case (j % 8)
        0: v = 16'h7FFF;
        1: v = 16'h8000;
        2: v = 16'h0000;
        3: v = 16'hFFFF;
        default: v = 16'(j*16);
      endcase
      exp_q.push_back({8'(j), v});
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < N_IN; k++) in_mem[k] = 16'($urandom_range(0, 2047)) - 16'd1024;
    for (int i = 0; i < N_IN*N_OUT; i++) w_mem[i] = 16'($urandom_range(0, 2047)) - 16'd1024;
    for (int j = 0; j < N_OUT; j++) b_mem[j] = 16'($urandom_range(0, 65535));
  endtask

  // Reference dot product: exact 64-bit sum, floor shift, clamp.
  task automatic push_model();
    for (int j = 0; j < N_OUT; j++) begin
      longint s, r;
      s = longint'($signed(b_mem[j])) * 256;
      for (int k = 0; k < N_IN; k++)
        s += longint'($signed(in_mem[k])) * longint'($signed(w_mem[j*N_IN + k]));
      r = s >>> 8;
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
      exp_q.push_back({8'(j), 16'(r)});
    end
  endtask

  task automatic start_pass();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    exp_done_cyc = cyc + PASS_CYCLES;
    first_wr_pending = 1'b1;
    wr_cnt = 0;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input bit poke_start);
    int t;
    t = 0;
    while (done !== 1'b1 && t < PASS_CYCLES + 100) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", done, 1'b1);
    if (poke_start) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("idle_after_done", busy, 1'b0);
    check("write_count", wr_cnt, 256);
    check("done_count", done_cnt, 1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    fill_unity();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Pass A: unity dot products, start re-pulsed mid-pass
    push_unity();
    start_pass();
    while (cyc < start_cyc + 10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < start_cyc + 5000) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_mid_pass", busy, 1'b1);
    wait_done(1'b0);

    // Pass B: saturation / truncation / bias passthrough, start in DONE cycle
    fill_edge();
    push_edge();
    start_pass();
    wait_done(1'b1);
    repeat (2) @(negedge clk);
    check("start_in_done_ignored", busy, 1'b0);

    // abort and start together in IDLE: nothing starts
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_beats_start", busy, 1'b0);

    // Pass C: random data, aborted at neuron 100 / k=30, then rerun
    fill_random();
    push_model();
    start_pass();
    begin
      int t;
      t = 0;
      while (!(busy && in_addr == 6'd30 && b_addr == 8'd100) && t < 7000) begin
        @(negedge clk);
        t++;
      end
    end
    check("abort_point_in_addr", in_addr, 6'd30);
    check("abort_point_b_addr", b_addr, 8'd100);
    check("writes_before_abort", wr_cnt, 100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    exp_q.delete();
    check("abort_busy", busy, 1'b0);
    check("abort_in_addr", in_addr, 6'd0);
    check("abort_b_addr", b_addr, 8'd0);
    repeat (200) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_no_more_writes", wr_cnt, 100);
    push_model();
    start_pass();
    wait_done(1'b0);

    // Pass D: asynchronous reset mid-pass, then unity pass again
    fill_unity();
    push_unity();
    start_pass();
    repeat (1000) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_unity();
    start_pass();
    wait_done(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
